// File: rtl/serial2parallel_rx.sv
// MSB-first serial-to-parallel receiver with frame_start alignment, a one-entry
// valid/ready output register and a sticky overrun flag for dropped words.
module serial2parallel_rx #(
    parameter int WIDTH        = 4,
    parameter bit REQUIRE_SYNC = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             frame_start,
    input  logic             out_ready,
    input  logic             overrun_clr,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    output logic             eow,
    output logic             overrun,
    output logic             busy
);

    // state      | meaning
    // WAIT_SYNC  | ignore bits until the first frame_start
    // SHIFT      | accumulate bits; words complete back-to-back
    typedef enum logic {
        ST_WAIT_SYNC = 1'b0,
        ST_SHIFT     = 1'b1
    } state_t;

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam state_t         ST_RESET = REQUIRE_SYNC ? ST_WAIT_SYNC : ST_SHIFT;

    state_t             state_q, state_d;
    logic [WIDTH-2:0]   shreg_q, shreg_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   par_out_q, par_out_d;
    logic               par_valid_q, par_valid_d;
    logic               eow_q, eow_d;
    logic               overrun_q, overrun_d;
    logic [WIDTH-1:0]   word;
    logic               complete;

    assign word = {shreg_q, ser_in};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RESET;
            shreg_q     <= '0;
            cnt_q       <= '0;
            par_out_q   <= '0;
            par_valid_q <= 1'b0;
            eow_q       <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            par_out_q   <= par_out_d;
            par_valid_q <= par_valid_d;
            eow_q       <= eow_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        complete = 1'b0;
        case (state_q)
            ST_WAIT_SYNC: begin
                if (frame_start) begin
                    state_d = ST_SHIFT;
                    if (ser_valid) begin
                        shreg_d = (WIDTH-1)'(ser_in);
                        cnt_d   = CW'(1);
                    end else begin
                        shreg_d = '0;
                        cnt_d   = '0;
                    end
                end
            end
            ST_SHIFT: begin
                // frame_start realigns even mid-word; the partial word is lost
                if (frame_start) begin
                    if (ser_valid) begin
                        shreg_d = (WIDTH-1)'(ser_in);
                        cnt_d   = CW'(1);
                    end else begin
                        shreg_d = '0;
                        cnt_d   = '0;
                    end
                end else if (ser_valid) begin
                    shreg_d = word[WIDTH-2:0];
                    if (cnt_q == CNT_LAST) begin
                        complete = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    always_comb begin
        par_out_d   = par_out_q;
        par_valid_d = par_valid_q;
        eow_d       = complete;
        overrun_d   = overrun_q;
        if (complete) begin
            if (!par_valid_q || out_ready) begin
                par_out_d   = word;
                par_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else begin
            if (par_valid_q && out_ready) begin
                par_valid_d = 1'b0;
            end
            if (overrun_clr) begin
                overrun_d = 1'b0;
            end
        end
        // a drop on a completion cycle wins over a simultaneous clear
        if (complete && par_valid_q && !out_ready) begin
            overrun_d = 1'b1;
        end else if (complete && overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    assign par_out   = par_out_q;
    assign par_valid = par_valid_q;
    assign eow       = eow_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q == ST_SHIFT) && (cnt_q != '0);

endmodule
